// File: rtl/fir_sample_line.sv
// Multi-channel circular sample history for the FIR MAC sequencer.
// Valid/ready sample ingress, 1-cycle registered tap reads, flush FSM to zero history.
module fir_sample_line #(
    parameter int DATA_W   = 16,
    parameter int TAPS     = 64,
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = $clog2(TAPS),
    parameter int CH_W     = ($clog2(CHANNELS) > 0 ? $clog2(CHANNELS) : 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flush_req,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CHANNELS-1:0] primed,
    output logic              ch_err
);

    typedef enum logic {FLUSH, RUN} state_t;

    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(TAPS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS-1);

    state_t state, state_next;
    logic [ADDR_W-1:0] fc;
    logic [ADDR_W-1:0] wp      [CHANNELS];
    logic [ADDR_W:0]   fill    [CHANNELS];
    logic [ADDR_W:0]   fill_nx [CHANNELS];
    logic [DATA_W-1:0] mem     [CHANNELS][TAPS];

    logic              in_ch_ok;
    logic              rd_ch_ok;
    logic              wr_ok;
    logic              flush_start;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_phys;

    assign in_ready    = (state == RUN);
    assign in_ch_ok    = int'(in_ch) < CHANNELS;
    assign rd_ch_ok    = int'(rd_ch) < CHANNELS;
    assign wr_ok       = in_valid && in_ready && in_ch_ok;
    assign flush_start = (state == RUN) && flush_req;
    // Pointers are only looked up for in-range channels.
    assign wr_addr     = in_ch_ok ? wp[in_ch] - 1'b1 : '0;
    assign rd_phys     = rd_ch_ok ? wp[rd_ch] + rd_addr : '0;

    always_comb begin
        state_next = state;
        case (state)
            FLUSH:   if (fc == LAST) state_next = RUN;
            RUN:     if (flush_req)  state_next = FLUSH;
            default: state_next = FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FLUSH;
            fc    <= '0;
        end else begin
            state <= state_next;
            // fc rests at zero in RUN so every flush starts from word 0.
            fc    <= (state == FLUSH) ? fc + 1'b1 : '0;
        end
    end

    // Flush entry clears the fill count even if a sample lands in the same cycle.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            fill_nx[c] = fill[c];
            if (flush_start)
                fill_nx[c] = '0;
            else if (wr_ok && int'(in_ch) == c && fill[c] != FULL)
                fill_nx[c] = fill[c] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp[c]   <= '0;
                fill[c] <= '0;
            end
            primed <= '0;
            ch_err <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_ok && int'(in_ch) == c)
                    wp[c] <= wr_addr;
                fill[c]   <= fill_nx[c];
                primed[c] <= (fill_nx[c] == FULL);
            end
            ch_err <= in_valid && in_ready && !in_ch_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == FLUSH) begin
                for (int c = 0; c < CHANNELS; c++)
                    mem[c][fc] <= '0;
            end else if (wr_ok) begin
                mem[in_ch][wr_addr] <= data_in;
            end
        end
    end

    // Reads sample the old pointer and old contents, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (state == RUN && rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_ch_ok ? mem[rd_ch][rd_phys] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sample_line.sv
// Directed bench for fir_sample_line; three channels so an out-of-range
// channel index (3) is expressible on the 2-bit channel ports.
module tb_fir_sample_line;

    localparam int DATA_W   = 16;
    localparam int TAPS     = 64;
    localparam int CHANNELS = 3;
    localparam int ADDR_W   = 6;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] data_in;
    logic              flush_req;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CHANNELS-1:0] primed;
    logic              ch_err;

    int checks = 0;
    int errors = 0;

    fir_sample_line #(
        .DATA_W(DATA_W), .TAPS(TAPS), .CHANNELS(CHANNELS)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .data_in(data_in),
        .flush_req(flush_req),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .primed(primed), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_ch    = ch;
        data_in  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [CH_W-1:0] ch,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        rd_en   = 1'b1;
        rd_ch   = ch;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        check_eq(tag, 32'(rd_data), 32'(exp));
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    // Counts cycles with in_ready low, bounded.
    task automatic wait_flush(output int n, input bit second_req);
        n = 0;
        while (!in_ready && n < 200) begin
            flush_req = second_req && (n == 9);
            tick();
            n++;
        end
        flush_req = 1'b0;
    endtask

    initial begin
        int n;
        int nz;
        bit rv_seen;

        reset = 1'b1; in_valid = 1'b0; in_ch = '0; data_in = '0;
        flush_req = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;

        // Reset state and initial flush length
        repeat (3) tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data",  32'(rd_data),  32'd0);
        check_eq("rst_primed",   32'(primed),   32'd0);
        check_eq("rst_ch_err",   32'(ch_err),   32'd0);

        reset = 1'b0;
        rd_en = 1'b1;
        n = 0;
        rv_seen = 1'b0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
            if (rd_valid) rv_seen = 1'b1;
        end
        rd_en = 1'b0;
        check_eq("init_flush_len", 32'(n), 32'd64);
        check_eq("flush_rd_ignored", 32'(rv_seen), 32'd0);
        read_chk("init_ch0_a0", 2'd0, 6'd0, 16'h0);
        read_chk("init_ch0_a63", 2'd0, 6'd63, 16'h0);
        read_chk("init_ch1_a17", 2'd1, 6'd17, 16'h0);
        check_eq("init_primed", 32'(primed), 32'd0);

        // Channel 0 fed 1..70
        for (int i = 1; i <= 70; i++) begin
            push(2'd0, 16'(i));
            if (i == 63) check_eq("primed_63", 32'(primed[0]), 32'd0);
            if (i == 64) check_eq("primed_64", 32'(primed[0]), 32'd1);
        end
        read_chk("ch1_empty", 2'd1, 6'd0, 16'h0);
        read_chk("ch0_newest", 2'd0, 6'd0, 16'd70);
        read_chk("ch0_oldest", 2'd0, 6'd63, 16'd7);
        read_chk("ch0_a1", 2'd0, 6'd1, 16'd69);
        tick();
        check_eq("idle_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("idle_rd_hold",  32'(rd_data),  32'd69);
        check_eq("primed_ch0_only", 32'(primed), 32'd1);

        // 100 samples total, then flush with a second ignored request
        for (int i = 0; i < 30; i++) push(2'd1, 16'(16'h0300 + i));
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check_eq("flush_entry_ready", 32'(in_ready), 32'd0);
        check_eq("flush_entry_primed", 32'(primed), 32'd0);
        wait_flush(n, 1'b1);
        check_eq("flush_len", 32'(n), 32'd64);
        nz = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int a = 0; a < TAPS; a++) begin
                rd_en = 1'b1; rd_ch = CH_W'(c); rd_addr = ADDR_W'(a);
                tick();
                if (rd_data !== 16'h0 || rd_valid !== 1'b1) nz++;
            end
        end
        rd_en = 1'b0;
        check_eq("flush_all_zero", 32'(nz), 32'd0);
        check_eq("flush_primed", 32'(primed), 32'd0);

        // Interleaved channels
        for (int i = 0; i < 10; i++) begin
            push(2'd0, 16'(16'h1000 + i));
            push(2'd1, 16'(16'h2000 + i));
        end
        read_chk("il_ch1_a3", 2'd1, 6'd3, 16'h2006);
        read_chk("il_ch0_a9", 2'd0, 6'd9, 16'h1000);
        read_chk("il_ch0_a10", 2'd0, 6'd10, 16'h0);
        read_chk("il_ch0_a0", 2'd0, 6'd0, 16'h1009);

        // Same-cycle read/write collision
        push(2'd0, 16'h0005);
        in_valid = 1'b1; in_ch = 2'd0; data_in = 16'hBEEF;
        rd_en = 1'b1; rd_ch = 2'd0; rd_addr = 6'd0;
        tick();
        in_valid = 1'b0; rd_en = 1'b0;
        check_eq("coll_old_data", 32'(rd_data), 32'h0005);
        check_eq("coll_valid", 32'(rd_valid), 32'd1);
        read_chk("coll_new_a0", 2'd0, 6'd0, 16'hBEEF);
        read_chk("coll_new_a1", 2'd0, 6'd1, 16'h0005);
        read_chk("coll_new_a2", 2'd0, 6'd2, 16'h1009);

        // Out-of-range channel
        push(2'd3, 16'h7777);
        check_eq("ch_err_pulse", 32'(ch_err), 32'd1);
        tick();
        check_eq("ch_err_clear", 32'(ch_err), 32'd0);
        read_chk("bad_ch_ch0", 2'd0, 6'd0, 16'hBEEF);
        read_chk("bad_ch_ch1", 2'd1, 6'd0, 16'h2009);
        read_chk("bad_ch_ch2", 2'd2, 6'd0, 16'h0);
        read_chk("rd_bad_ch", 2'd3, 6'd5, 16'h0);
        check_eq("bad_ch_primed", 32'(primed), 32'd0);

        // Reset mid-stream
        read_chk("pre_rst_read", 2'd0, 6'd0, 16'hBEEF);
        reset = 1'b1; in_valid = 1'b1; in_ch = 2'd3; data_in = 16'h1234;
        rd_en = 1'b1; rd_ch = 2'd0; rd_addr = 6'd0;
        tick();
        in_valid = 1'b0; rd_en = 1'b0;
        check_eq("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_ch_err", 32'(ch_err), 32'd0);
        reset = 1'b0;
        wait_flush(n, 1'b0);
        check_eq("mid_rst_flush_len", 32'(n), 32'd64);
        read_chk("post_rst_a0", 2'd0, 6'd0, 16'h0);
        push(2'd0, 16'hABCD);
        read_chk("post_rst_new", 2'd0, 6'd0, 16'hABCD);
        read_chk("post_rst_a63", 2'd0, 6'd63, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
